control_sequencer: RTL and testbench

- Moore-style control unit that drives the datapath's control signals, replacing hand-sequenced T0..T5 stimulus.
- Runs a 3-step fetch (T0-T2), then a decode-driven execute of 3 steps, or 4 with MULDIV_EN.
- Parametrised in register count and opcode width.
- Sits beside the datapath. Reads the datapath IR register output and drives one-hot register select plus the bus/ALU strobes.

---
 rtl/ctrl_seq_pkg.sv | 50 +++++
 rtl/ctrl_seq_decode.sv | 27 ++
 rtl/control_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_seq_pkg.sv
// rtl/ctrl_seq_pkg.sv - shared states, opcode constants and IR field positions for control_sequencer
package ctrl_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_T0     = 4'd1,
        ST_T1     = 4'd2,
        ST_T2     = 4'd3,
        ST_T3     = 4'd4,
        ST_T4     = 4'd5,
        ST_T5     = 4'd6,
        ST_T6     = 4'd7,
        ST_HALTED = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_MULDIV  = 3'd1,
        CLS_NOP     = 3'd2,
        CLS_HALT    = 3'd3,
        CLS_ILLEGAL = 3'd4
    } op_class_e;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Fields are packed from the MSB down: op, ra, rb, rc.
    function automatic int op_lsb(input int ir_w, input int opw);
        return ir_w - opw;
    endfunction

    function automatic int ra_lsb(input int ir_w, input int opw, input int rw);
        return ir_w - opw - rw;
    endfunction

    function automatic int rb_lsb(input int ir_w, input int opw, input int rw);
        return ir_w - opw - 2 * rw;
    endfunction

    function automatic int rc_lsb(input int ir_w, input int opw, input int rw);
        return ir_w - opw - 3 * rw;
    endfunction

endpackage

// File: rtl/ctrl_seq_decode.sv
// rtl/ctrl_seq_decode.sv - opcode to {class, illegal} decoder; MUL/DIV decoded only with CTRL_SEQ_MULDIV_EN
module ctrl_seq_decode
    import ctrl_seq_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0] op,
    output op_class_e      op_class,
    output logic           illegal
);

    // Classify the opcode; anything unlisted is illegal
    always_comb begin
        op_class = CLS_ILLEGAL;
        case (op)
            OPW'(OP_ADD), OPW'(OP_SUB), OPW'(OP_AND), OPW'(OP_OR): op_class = CLS_RTYPE;
`ifdef CTRL_SEQ_MULDIV_EN
            OPW'(OP_MUL), OPW'(OP_DIV):                           op_class = CLS_MULDIV;
`endif
            OPW'(OP_NOP):                                         op_class = CLS_NOP;
            OPW'(OP_HALT):                                        op_class = CLS_HALT;
            default:                                              op_class = CLS_ILLEGAL;
        endcase
        illegal = (op_class == CLS_ILLEGAL);
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - Moore fetch/decode/execute control unit; CTRL_SEQ_MULDIV_EN adds MUL/DIV (T6)
module control_sequencer
    import ctrl_seq_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int OPW      = 5,
    parameter int IR_W     = 32
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                Run,
    input  logic                Stop,
    input  logic                Mem_Ready,
    input  logic [IR_W-1:0]     IR,
    output logic                PCout,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                MDRout,
    output logic                MARin,
    output logic                Zin,
    output logic                PCin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                HIin,
    output logic                LOin,
    output logic                IncPC,
    output logic                Read,
    output logic [OPW-1:0]      ALU_op,
    output logic [NUM_REGS-1:0] Rout,
    output logic [NUM_REGS-1:0] Rin,
    output logic                Busy,
    output logic                Illegal
);

    localparam int RW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int OP_LSB = op_lsb(IR_W, OPW);
    localparam int RA_LSB = ra_lsb(IR_W, OPW, RW);
    localparam int RB_LSB = rb_lsb(IR_W, OPW, RW);
    localparam int RC_LSB = rc_lsb(IR_W, OPW, RW);

    state_e          state_q, state_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [RW-1:0]   ra_q, ra_d;
    logic [RW-1:0]   rb_q, rb_d;
    logic [RW-1:0]   rc_q, rc_d;
    logic            muldiv_q, muldiv_d;
    logic            illegal_q, illegal_d;
    logic            stop_pend_q, stop_pend_d;
    logic            t1_wait_q, t1_wait_d;

    logic [OPW-1:0]  ir_op;
    logic [RW-1:0]   ir_ra, ir_rb, ir_rc;
    op_class_e       dec_class;
    logic            dec_illegal;
    logic            idx_bad;
    state_e          end_state;

    assign ir_op = IR[OP_LSB +: OPW];
    assign ir_ra = IR[RA_LSB +: RW];
    assign ir_rb = IR[RB_LSB +: RW];
    assign ir_rc = IR[RC_LSB +: RW];

    if (RC_LSB > 0) begin : g_ir_spare
        logic unused_ir_low;
        assign unused_ir_low = ^IR[RC_LSB-1:0];
    end

    ctrl_seq_decode #(
        .OPW      (OPW)
    ) u_decode (
        .op       (ir_op),
        .op_class (dec_class),
        .illegal  (dec_illegal)
    );

    function automatic logic [NUM_REGS-1:0] onehot(input logic [RW-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v = '0;
        if (32'(idx) < 32'(NUM_REGS)) v[idx] = 1'b1;
        return v;
    endfunction

    // Out-of-range register fields are flagged at decode time
    always_comb begin
        idx_bad = (32'(ir_ra) >= 32'(NUM_REGS)) ||
                  (32'(ir_rb) >= 32'(NUM_REGS)) ||
                  (32'(ir_rc) >= 32'(NUM_REGS));
        // Stop (pending or arriving now) beats Run at an instruction boundary
        end_state = (Run && !(stop_pend_q || Stop)) ? ST_T0 : ST_IDLE;
    end

    // Next-state, field capture and sticky flag logic
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        rc_d        = rc_q;
        muldiv_d    = muldiv_q;
        illegal_d   = illegal_q;
        stop_pend_d = stop_pend_q | Stop;
        t1_wait_d   = (state_q == ST_T1);
        case (state_q)
            ST_IDLE:   if (Run && !Stop) state_d = ST_T0;
            ST_T0:     state_d = ST_T1;
            ST_T1:     if (Mem_Ready) state_d = ST_T2;
            ST_T2: begin
                op_d = ir_op;
                ra_d = ir_ra;
                rb_d = ir_rb;
                rc_d = ir_rc;
                case (dec_class)
                    CLS_RTYPE, CLS_MULDIV: begin
                        muldiv_d = (dec_class == CLS_MULDIV);
                        if (idx_bad) illegal_d = 1'b1;
                        state_d = ST_T3;
                    end
                    CLS_HALT:  state_d = ST_HALTED;
                    default: begin
                        if (dec_illegal) illegal_d = 1'b1;
                        stop_pend_d = 1'b0;
                        state_d     = end_state;
                    end
                endcase
            end
            ST_T3:     state_d = ST_T4;
            ST_T4:     state_d = ST_T5;
            ST_T5: begin
                if (muldiv_q) begin
                    state_d = ST_T6;
                end else begin
                    stop_pend_d = 1'b0;
                    state_d     = end_state;
                end
            end
            ST_T6: begin
                stop_pend_d = 1'b0;
                state_d     = end_state;
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State and captured-field registers
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            rc_q        <= '0;
            muldiv_q    <= 1'b0;
            illegal_q   <= 1'b0;
            stop_pend_q <= 1'b0;
            t1_wait_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            rc_q        <= rc_d;
            muldiv_q    <= muldiv_d;
            illegal_q   <= illegal_d;
            stop_pend_q <= stop_pend_d;
            t1_wait_q   <= t1_wait_d;
        end
    end

    // Moore output decode from registered state and fields only
    always_comb begin
        PCout   = (state_q == ST_T0);
        MARin   = (state_q == ST_T0);
        IncPC   = (state_q == ST_T0);
        Zin     = (state_q == ST_T0) || (state_q == ST_T4);
        Zlowout = (state_q == ST_T1) || (state_q == ST_T5);
        PCin    = (state_q == ST_T1) && !t1_wait_q;
        Read    = (state_q == ST_T1);
        MDRin   = (state_q == ST_T1);
        MDRout  = (state_q == ST_T2);
        IRin    = (state_q == ST_T2);
        Yin     = (state_q == ST_T3);
        ALU_op  = (state_q == ST_T4) ? op_q : '0;
        Rout    = (state_q == ST_T3) ? onehot(rb_q) :
                  (state_q == ST_T4) ? onehot(rc_q) : '0;
        Rin     = (state_q == ST_T5 && !muldiv_q) ? onehot(ra_q) : '0;
`ifdef CTRL_SEQ_MULDIV_EN
        LOin     = (state_q == ST_T5) && muldiv_q;
        HIin     = (state_q == ST_T6);
        Zhighout = (state_q == ST_T6);
`else
        LOin     = 1'b0;
        HIin     = 1'b0;
        Zhighout = 1'b0;
`endif
        Busy    = (state_q != ST_IDLE) && (state_q != ST_HALTED);
        Illegal = illegal_q;
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer (honours CTRL_SEQ_MULDIV_EN)
module tb_control_sequencer;

    logic        Clock, Resetn, Run, Stop, Mem_Ready;
    logic [31:0] IR;
    logic        PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin;
    logic        IRin, Yin, HIin, LOin, IncPC, Read, Busy, Illegal;
    logic [4:0]  ALU_op;
    logic [15:0] Rout, Rin;
    logic [13:0] ctl;

    int total = 0;
    int bad   = 0;

    // {PCout,Zlowout,Zhighout,MDRout,MARin,Zin,PCin,MDRin,IRin,Yin,HIin,LOin,IncPC,Read}
    localparam logic [13:0] C_IDLE = 14'b00000000000000;
    localparam logic [13:0] C_T0   = 14'b10001100000010;
    localparam logic [13:0] C_T1F  = 14'b01000011000001;
    localparam logic [13:0] C_T1W  = 14'b01000001000001;
    localparam logic [13:0] C_T2   = 14'b00010000100000;
    localparam logic [13:0] C_T3   = 14'b00000000010000;
    localparam logic [13:0] C_T4   = 14'b00000100000000;
    localparam logic [13:0] C_T5   = 14'b01000000000000;
    localparam logic [13:0] C_T5M  = 14'b01000000000100;
    localparam logic [13:0] C_T6   = 14'b00100000001000;

`ifdef CTRL_SEQ_MULDIV_EN
    localparam logic MUL_ILL = 1'b0;
`else
    localparam logic MUL_ILL = 1'b1;
`endif

    assign ctl = {PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin,
                  IRin, Yin, HIin, LOin, IncPC, Read};

    control_sequencer dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .Run       (Run),
        .Stop      (Stop),
        .Mem_Ready (Mem_Ready),
        .IR        (IR),
        .PCout     (PCout),
        .Zlowout   (Zlowout),
        .Zhighout  (Zhighout),
        .MDRout    (MDRout),
        .MARin     (MARin),
        .Zin       (Zin),
        .PCin      (PCin),
        .MDRin     (MDRin),
        .IRin      (IRin),
        .Yin       (Yin),
        .HIin      (HIin),
        .LOin      (LOin),
        .IncPC     (IncPC),
        .Read      (Read),
        .ALU_op    (ALU_op),
        .Rout      (Rout),
        .Rin       (Rin),
        .Busy      (Busy),
        .Illegal   (Illegal)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s: got %h want %h", tag, fld, obs, exp);
        end
    endtask

    task automatic exp_st(input string tag, input logic [13:0] c, input logic [15:0] ro,
                          input logic [15:0] ri, input logic [4:0] alu, input logic busy, input logic ill);
        chk(tag, "ctl",     32'(ctl),     32'(c));
        chk(tag, "Rout",    32'(Rout),    32'(ro));
        chk(tag, "Rin",     32'(Rin),     32'(ri));
        chk(tag, "ALU_op",  32'(ALU_op),  32'(alu));
        chk(tag, "Busy",    32'(Busy),    32'(busy));
        chk(tag, "Illegal", 32'(Illegal), 32'(ill));
    endtask

    initial begin
        Resetn = 1'b0; Run = 1'b0; Stop = 1'b0; Mem_Ready = 1'b1; IR = '0;
        repeat (2) tick();
        exp_st("reset", C_IDLE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        Resetn = 1'b1;
        tick();
        exp_st("idle", C_IDLE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);

        // AND r1 = r2 & r3
        IR = 32'h28918000; Run = 1'b1;
        tick(); exp_st("and_t0", C_T0,  16'h0,    16'h0,    5'd0,     1'b1, 1'b0);
        tick(); exp_st("and_t1", C_T1F, 16'h0,    16'h0,    5'd0,     1'b1, 1'b0);
        tick(); exp_st("and_t2", C_T2,  16'h0,    16'h0,    5'd0,     1'b1, 1'b0);
        tick(); exp_st("and_t3", C_T3,  16'h0004, 16'h0,    5'd0,     1'b1, 1'b0);
        tick(); exp_st("and_t4", C_T4,  16'h0008, 16'h0,    5'b00101, 1'b1, 1'b0);
        tick(); exp_st("and_t5", C_T5,  16'h0,    16'h0002, 5'd0,     1'b1, 1'b0);
        tick(); exp_st("and_c7", C_T0,  16'h0,    16'h0,    5'd0,     1'b1, 1'b0);

        // memory wait of three cycles, then ADD with a Stop pulse in T3
        Mem_Ready = 1'b0; IR = 32'h18918000;
        tick(); exp_st("mw_c1", C_T1F, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
        tick(); exp_st("mw_c2", C_T1W, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
        tick(); exp_st("mw_c3", C_T1W, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
        tick(); exp_st("mw_c4", C_T1W, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
        Mem_Ready = 1'b1;
        tick(); exp_st("mw_t2",  C_T2, 16'h0,    16'h0,    5'd0,     1'b1, 1'b0);
        tick(); exp_st("add_t3", C_T3, 16'h0004, 16'h0,    5'd0,     1'b1, 1'b0);
        Stop = 1'b1;
        tick(); Stop = 1'b0;
        exp_st("add_t4", C_T4, 16'h0008, 16'h0,    5'b00011, 1'b1, 1'b0);
        tick(); exp_st("add_t5", C_T5, 16'h0,    16'h0002, 5'd0,     1'b1, 1'b0);
        tick(); Run = 1'b0;
        exp_st("stop_idle",  C_IDLE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        tick(); exp_st("stop_idle2", C_IDLE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);

        // undefined opcode 11111 is skipped and sets sticky Illegal
        IR = 32'hF8000000; Run = 1'b1;
        tick(); exp_st("ill_t0",   C_T0,  16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
        tick(); exp_st("ill_t1",   C_T1F, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
        tick(); exp_st("ill_t2",   C_T2,  16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
        tick(); exp_st("ill_next", C_T0,  16'h0, 16'h0, 5'd0, 1'b1, 1'b1);
        IR = 32'h28918000;
        tick(); exp_st("ill_and_t1", C_T1F, 16'h0,    16'h0,    5'd0,     1'b1, 1'b1);
        tick(); exp_st("ill_and_t2", C_T2,  16'h0,    16'h0,    5'd0,     1'b1, 1'b1);
        tick(); exp_st("ill_and_t3", C_T3,  16'h0004, 16'h0,    5'd0,     1'b1, 1'b1);
        tick(); exp_st("ill_and_t4", C_T4,  16'h0008, 16'h0,    5'b00101, 1'b1, 1'b1);
        tick(); exp_st("ill_and_t5", C_T5,  16'h0,    16'h0002, 5'd0,     1'b1, 1'b1);
        tick(); exp_st("ill_and_t0", C_T0,  16'h0,    16'h0,    5'd0,     1'b1, 1'b1);

        // HALT parks the sequencer until reset, ignoring Run
        IR = 32'hD8000000;
        tick(); exp_st("halt_t1", C_T1F,  16'h0, 16'h0, 5'd0, 1'b1, 1'b1);
        tick(); exp_st("halt_t2", C_T2,   16'h0, 16'h0, 5'd0, 1'b1, 1'b1);
        tick(); exp_st("halted",  C_IDLE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b1);
        tick(); exp_st("halted2", C_IDLE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b1);
        Resetn = 1'b0;
        #2;
        exp_st("halt_rst", C_IDLE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        Resetn = 1'b1; Run = 1'b0;
        tick(); exp_st("post_rst", C_IDLE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);

        // MUL r1 = r2 * r3
        IR = 32'h78918000; Run = 1'b1;
        tick(); exp_st("mul_t0", C_T0,  16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
        tick(); exp_st("mul_t1", C_T1F, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
        tick(); exp_st("mul_t2", C_T2,  16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
`ifdef CTRL_SEQ_MULDIV_EN
        tick(); exp_st("mul_t3", C_T3,  16'h0004, 16'h0, 5'd0,     1'b1, 1'b0);
        tick(); exp_st("mul_t4", C_T4,  16'h0008, 16'h0, 5'b01111, 1'b1, 1'b0);
        tick(); exp_st("mul_t5", C_T5M, 16'h0,    16'h0, 5'd0,     1'b1, 1'b0);
        tick(); exp_st("mul_t6", C_T6,  16'h0,    16'h0, 5'd0,     1'b1, 1'b0);
        tick(); exp_st("mul_c8", C_T0,  16'h0,    16'h0, 5'd0,     1'b1, 1'b0);
`else
        tick(); exp_st("mul_ill", C_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b1);
`endif

        // ADD interrupted by reset in T4
        IR = 32'h18918000;
        tick(); exp_st("rst_add_t1", C_T1F, 16'h0,    16'h0, 5'd0,     1'b1, MUL_ILL);
        tick(); exp_st("rst_add_t2", C_T2,  16'h0,    16'h0, 5'd0,     1'b1, MUL_ILL);
        tick(); exp_st("rst_add_t3", C_T3,  16'h0004, 16'h0, 5'd0,     1'b1, MUL_ILL);
        tick(); exp_st("rst_add_t4", C_T4,  16'h0008, 16'h0, 5'b00011, 1'b1, MUL_ILL);
        #2 Resetn = 1'b0;
        #1;
        exp_st("t4_rst", C_IDLE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        Resetn = 1'b1; Run = 1'b0;
        tick(); exp_st("t4_rst_idle", C_IDLE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
